seg_display_scheduler: RTL
==========================

Name: seg_display_scheduler

Overview:
- Time-shares the single 4-digit seven-segment display between up to 4 requesters, such as CPU register file taps, PC, ALU result and debug value.
- Selects one 16-bit source per page and drives the display driver's 16-bit din input.
- Pages are chosen by auto-rotation on a dwell timer or by a debounced "next" button.
- A one-shot alert from any requester pre-empts the current page for a fixed time.

Parameters:
- NSRC, 4: number of requesters; fixed at 4; page index is 2 bits.
- DWELL_CYCLES, 50_000_000: clk cycles a page is shown in auto mode.
- DEB_CYCLES, 1_000_000: clk cycles btn_next must be stable to be accepted.
- ALERT_CYCLES, 100_000_000: clk cycles an alert page is held.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- src_data  in  64  packed sources; source i at [16*i+15:16*i].
- src_valid  in  4  level; source i wants display time.
- alert_req  in  4  1-cycle pulse; source i requests pre-emption.
- btn_next  in  1  raw asynchronous push-button, active-high.
- auto_en  in  1  level; 1 = auto-rotate, 0 = manual only.
- disp_data  out  16  value for the display driver din.
- page  out  2  index of the source currently shown.
- blank  out  1  1 = nothing valid; the display shows 0000.
- alert_active  out  1  1 while an alert page is shown.

Behaviour:
- Reset values:
  - state=IDLE, page=0, disp_data=16'h0000, blank=1, alert_active=0.
  - dwell_cnt=0, alert_cnt=0, saved_page=0.
  - Debouncer cleared. Any reset mid-operation, including mid-alert or mid-debounce, returns to these values on that edge.
- Outputs are registered.
  - disp_data = src_data[page] is sampled every cycle, with 1 cycle latency from a change in src_data or page.
  - disp_data = 0 while blank=1.
- Button path (sub-module):
  - 2-flop synchronizer, then a stability counter.
  - Emits next_pulse, 1 cycle wide, once per accepted 0->1 transition.
  - The level must be stable for DEB_CYCLES consecutive cycles.
  - Bounces shorter than DEB_CYCLES produce no pulse.
- "Next valid after p" means a round-robin search p+1, p+2, p+3, p (wrapping 3->0) for the first set src_valid bit.
- FSM state IDLE:
  - blank=1.
  - If any src_valid bit is set: go to SHOW with page = lowest-index valid source, dwell_cnt=0.
- FSM state SHOW:
  - blank=0.
  - dwell_cnt increments only when auto_en=1. At DWELL_CYCLES-1: page <- next valid, dwell_cnt <- 0.
  - next_pulse: page <- next valid, dwell_cnt <- 0.
  - A dwell expiry and next_pulse in the same cycle produce exactly one advance.
  - If src_valid[page]=0: advance to next valid on the next edge. If none are valid: go to IDLE.
  - If only the current source is valid: advances keep the same page and dwell_cnt restarts.
- FSM state ALERT:
  - Entry from any state on any alert_req bit. The lowest index wins if several bits are set.
  - On entry:
    - saved_page <- page, captured only when entering from SHOW/IDLE.
    - page <- i, alert_cnt <- 0, alert_active=1, blank=0.
  - The alert page is shown even if src_valid[i]=0.
  - dwell_cnt is frozen.
  - A new alert_req while in ALERT: page <- new i, alert_cnt <- 0, saved_page is unchanged.
  - Exit at alert_cnt = ALERT_CYCLES-1, or on next_pulse (early cancel):
    - If src_valid[saved_page]=1: page <- saved_page, go to SHOW, dwell_cnt resumes from its frozen value.
    - Else: next valid after saved_page.
    - Else, if none are valid: go to IDLE.
  - An alert_req in the same cycle as the exit condition wins: stay in ALERT and restart.
- auto_en toggling:
  - Takes effect on the next cycle.
  - dwell_cnt holds its value while auto_en=0; it is not cleared.
- Counters:
  - Width is clog2 of the respective parameter.
  - They never exceed parameter-1; wrap is explicit to 0.

Decomposition:
- Package seg_sched_pkg:
  - State enum {IDLE, SHOW, ALERT}.
  - PAGE_W=2, DATA_W=16.
  - Round-robin "next valid" function (4-bit mask, 2-bit start) returning index plus a found flag.
- Sub-module btn_debounce, parameter DEB_CYCLES; ports clk, rst, btn_raw, pulse.

Test Plan (DWELL_CYCLES=8, DEB_CYCLES=4, ALERT_CYCLES=16):
- Reset, src_valid=0 -> blank=1, disp_data=0000, page=0. Then src_valid=4'b0100 -> page=2 two cycles later; disp_data=src2 one cycle after page changes.
- src_valid=4'b1011, auto_en=1, src_data=AAAA,BBBB,CCCC,DDDD -> page sequence 0,1,3,0, advancing every 8 cycles; disp_data=AAAA,BBBB,DDDD.
- auto_en=0, btn_next bouncing 1-0-1 at 2-cycle spacing then held high 10 cycles -> exactly one advance, occurring 2+4 cycles after the stable rise. No advance during the bounce.
- In SHOW page=1, pulse alert_req=4'b1000 -> page=3, alert_active=1 for 16 cycles, then page=1 with dwell_cnt resumed. Repeat with src_valid[1] cleared during the alert -> returns to the next valid page after 1.
- Simultaneous events: alert_req=4'b0110 -> page=1. Dwell expiry coincident with next_pulse -> single advance. Exit cycle coincident with alert_req[2] -> stays in ALERT with page=2.
- Assert rst mid-alert and mid-debounce -> all outputs at reset values the next cycle; no spurious next_pulse after rst deasserts with btn_next held high.

Source files
------------

// File: rtl/seg_sched_pkg.sv
// Shared types and the round-robin source search for the seven-segment
// display scheduler.
package seg_sched_pkg;

  localparam int NSRC   = 4;
  localparam int PAGE_W = 2;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ALERT = 2'd2
  } state_t;

  typedef struct packed {
    logic              found;
    logic [PAGE_W-1:0] idx;
  } rr_t;

  // Searches start+1, start+2, start+3, start in that order; the start index
  // itself is the last candidate so a lone valid source selects itself.
  function automatic rr_t next_valid(input logic [NSRC-1:0] mask,
                                     input logic [PAGE_W-1:0] start);
    rr_t               r;
    logic [PAGE_W-1:0] cand;
    r.found = 1'b0;
    r.idx   = start;
    for (int k = 1; k <= NSRC; k++) begin
      cand = start + PAGE_W'(k);
      if (!r.found && mask[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_display_scheduler_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, and a
// single-cycle pulse for each accepted press.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int             CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          armed;
  logic [CW-1:0] cnt;

  // Until the first stable level is learned after reset, the level is adopted
  // silently, so a button held through reset never yields a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (!armed) begin
        if (sync2 != level) begin
          level <= sync2;
          cnt   <= CW'(1);
        end else if (cnt == CNT_MAX) begin
          armed <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (sync2 != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync2;
          cnt   <= '0;
          pulse <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-shares one 4-digit display between four 16-bit sources with dwell
// rotation, a debounced "next" button and pre-empting alerts.
//   state | meaning
//   IDLE  | no source valid, display blanked to 0000
//   SHOW  | normal page display, dwell timer / button advance
//   ALERT | alert page held for ALERT_CYCLES, dwell timer frozen
module seg_display_scheduler
  import seg_sched_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int ALERT_CYCLES = 100_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W*NSRC-1:0] src_data,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC-1:0]        alert_req,
  input  logic                   btn_next,
  input  logic                   auto_en,
  output logic [DATA_W-1:0]      disp_data,
  output logic [PAGE_W-1:0]      page,
  output logic                   blank,
  output logic                   alert_active
);

  localparam int                  DWELL_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int                  ALERT_W   = (ALERT_CYCLES > 1) ? $clog2(ALERT_CYCLES) : 1;
  localparam logic [DWELL_W-1:0]  DWELL_MAX = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [ALERT_W-1:0]  ALERT_MAX = ALERT_W'(ALERT_CYCLES - 1);
  localparam logic [PAGE_W-1:0]   LAST_IDX  = PAGE_W'(NSRC - 1);

  state_t             state, state_nxt;
  logic [PAGE_W-1:0]  page_nxt;
  logic [PAGE_W-1:0]  saved_page, saved_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
  logic [ALERT_W-1:0] alert_cnt, alert_nxt;
  logic               next_pulse;
  rr_t                rr_cur, rr_saved, rr_low, rr_alert;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_next),
    .pulse  (next_pulse)
  );

  always_comb begin
    rr_cur    = next_valid(src_valid, page);
    rr_saved  = next_valid(src_valid, saved_page);
    rr_low    = next_valid(src_valid, LAST_IDX);
    rr_alert  = next_valid(alert_req, LAST_IDX);
    state_nxt = state;
    page_nxt  = page;
    saved_nxt = saved_page;
    dwell_nxt = dwell_cnt;
    alert_nxt = alert_cnt;

    // An alert request outranks every other event, including an alert exit.
    if (|alert_req) begin
      state_nxt = ALERT;
      page_nxt  = rr_alert.idx;
      alert_nxt = '0;
      if (state != ALERT) saved_nxt = page;
    end else begin
      unique case (state)
        IDLE: begin
          if (rr_low.found) begin
            state_nxt = SHOW;
            page_nxt  = rr_low.idx;
            dwell_nxt = '0;
          end
        end
        SHOW: begin
          if (!src_valid[page]) begin
            dwell_nxt = '0;
            if (rr_cur.found) page_nxt  = rr_cur.idx;
            else              state_nxt = IDLE;
          end else if (next_pulse || (auto_en && dwell_cnt == DWELL_MAX)) begin
            page_nxt  = rr_cur.idx;
            dwell_nxt = '0;
          end else if (auto_en) begin
            dwell_nxt = dwell_cnt + 1'b1;
          end
        end
        ALERT: begin
          if (next_pulse || alert_cnt == ALERT_MAX) begin
            if (src_valid[saved_page]) begin
              state_nxt = SHOW;
              page_nxt  = saved_page;
            end else if (rr_saved.found) begin
              state_nxt = SHOW;
              page_nxt  = rr_saved.idx;
              dwell_nxt = '0;
            end else begin
              state_nxt = IDLE;
              dwell_nxt = '0;
            end
          end else begin
            alert_nxt = alert_cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      page         <= '0;
      saved_page   <= '0;
      dwell_cnt    <= '0;
      alert_cnt    <= '0;
      disp_data    <= '0;
      blank        <= 1'b1;
      alert_active <= 1'b0;
    end else begin
      state        <= state_nxt;
      page         <= page_nxt;
      saved_page   <= saved_nxt;
      dwell_cnt    <= dwell_nxt;
      alert_cnt    <= alert_nxt;
      blank        <= (state_nxt == IDLE);
      alert_active <= (state_nxt == ALERT);
      disp_data    <= (state_nxt == IDLE) ? '0 : src_data[DATA_W*page +: DATA_W];
    end
  end

endmodule
